// File: rtl/wb_buffer.sv
// Write-back buffer: queues late results and drains one per cycle into the register file, with decode-side forwarding.
// Push-to-RegWr latency >= 1 cycle; push_ready drops when full, and drain is gated by drain_en and ~empty.
module wb_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [2:0]               push_rd,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     drain_en,
  output logic                     RegWr,
  output logic [2:0]               Rd,
  output logic [WIDTH-1:0]         WBus,
  input  logic [2:0]               Rs1,
  input  logic [2:0]               Rs2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [WIDTH-1:0]         fwd1,
  output logic [WIDTH-1:0]         fwd2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]       rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_fire;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = ~full;
  assign count      = count_q;
  assign push_fire  = push_valid & push_ready;
  assign RegWr      = drain_en & ~empty;
  assign Rd         = empty ? 3'd0 : rd_q[head_q];
  assign WBus       = empty ? '0 : data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) tail_d = tail_q + 1'b1;
      if (RegWr)     head_d = head_q + 1'b1;
      case ({push_fire, RegWr})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_fire && !flush) begin
        rd_q[tail_q]   <= push_rd;
        data_q[tail_q] <= push_data;
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (rd_q[head_q + AW'(i)] == Rs1) begin
          hit1 = 1'b1;
          fwd1 = data_q[head_q + AW'(i)];
        end
        if (rd_q[head_q + AW'(i)] == Rs2) begin
          hit2 = 1'b1;
          fwd2 = data_q[head_q + AW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: table-driven fill/drain plus scoreboarded corner-case sequences.
module tb_wb_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             push_valid = 1'b0;
  logic [2:0]       push_rd = '0;
  logic [WIDTH-1:0] push_data = '0;
  logic             push_ready;
  logic             drain_en = 1'b0;
  logic             RegWr;
  logic [2:0]       Rd;
  logic [WIDTH-1:0] WBus;
  logic [2:0]       Rs1 = '0;
  logic [2:0]       Rs2 = '0;
  logic             hit1, hit2;
  logic [WIDTH-1:0] fwd1, fwd2;
  logic [2:0]       count;
  logic             full, empty;

  wb_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_rd(push_rd), .push_data(push_data), .push_ready(push_ready),
    .drain_en(drain_en), .RegWr(RegWr), .Rd(Rd), .WBus(WBus),
    .Rs1(Rs1), .Rs2(Rs2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    logic        pv;
    logic [2:0]  prd;
    logic [15:0] pd;
    logic        de;
    logic [2:0]  exp_cnt;
    logic        exp_wr;
    logic [2:0]  exp_rd;
    logic [15:0] exp_wb;
    logic        exp_full;
  } vec_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        s_wr, s_hit1, s_hit2, s_empty, s_full;
  logic [2:0]  s_rd, s_cnt;
  logic [15:0] s_wb, s_fwd1, s_fwd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_lookup(input logic [2:0] rs, output logic h, output logic [15:0] v);
    h = 1'b0;
    v = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].rd == rs) begin
        h = 1'b1;
        v = sb[i].d;
        break;
      end
    end
  endfunction

  // Entered #1 after a posedge; drives one cycle, checks at negedge, updates the model after the edge.
  task automatic cyc(input logic pv, input logic [2:0] prd, input logic [15:0] pd,
                     input logic de, input logic fl, input logic [2:0] r1, input logic [2:0] r2);
    logic exp_pop, exp_push, eh1, eh2;
    logic [15:0] ef1, ef2;
    push_valid = pv; push_rd = prd; push_data = pd;
    drain_en = de; flush = fl; Rs1 = r1; Rs2 = r2;
    @(negedge clk);
    s_wr = RegWr; s_rd = Rd; s_wb = WBus; s_cnt = count; s_full = full; s_empty = empty;
    s_hit1 = hit1; s_hit2 = hit2; s_fwd1 = fwd1; s_fwd2 = fwd2;
    exp_pop  = de && (sb.size() != 0);
    exp_push = pv && (sb.size() < DEPTH);
    chk("RegWr", s_wr, exp_pop);
    chk("Rd", s_rd, (sb.size() != 0) ? sb[0].rd : 3'd0);
    chk("WBus", s_wb, (sb.size() != 0) ? sb[0].d : 16'd0);
    chk("count", s_cnt, sb.size());
    chk("empty", s_empty, sb.size() == 0);
    chk("full", s_full, sb.size() == DEPTH);
    chk("push_ready", push_ready, sb.size() != DEPTH);
    model_lookup(r1, eh1, ef1);
    model_lookup(r2, eh2, ef2);
    chk("hit1", s_hit1, eh1);
    chk("fwd1", s_fwd1, ef1);
    chk("hit2", s_hit2, eh2);
    chk("fwd2", s_fwd2, ef2);
    @(posedge clk);
    #1;
    if (exp_pop) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (exp_push) sb.push_back('{rd: prd, d: pd});
  endtask

  task automatic idle(input logic de);
    cyc(1'b0, 3'd0, 16'd0, de, 1'b0, 3'd0, 3'd0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 3'd1, 16'h0011, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 3'd2, 16'h0022, 1'b0, 3'd1, 1'b0, 3'd1, 16'h0011, 1'b0};
    tbl[2] = '{1'b1, 3'd3, 16'h0033, 1'b0, 3'd2, 1'b0, 3'd1, 16'h0011, 1'b0};
    tbl[3] = '{1'b1, 3'd4, 16'h0044, 1'b0, 3'd3, 1'b0, 3'd1, 16'h0011, 1'b0};
    tbl[4] = '{1'b1, 3'd5, 16'h0055, 1'b0, 3'd4, 1'b0, 3'd1, 16'h0011, 1'b1};
    tbl[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1, 3'd1, 16'h0011, 1'b1};
    tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd2, 16'h0022, 1'b0};
    tbl[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 3'd3, 16'h0033, 1'b0};
    tbl[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 3'd4, 16'h0044, 1'b0};
    tbl[9] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0};

    // Reset state
    #12;
    chk("rst_RegWr", RegWr, 1'b0);
    chk("rst_Rd", Rd, 3'd0);
    chk("rst_WBus", WBus, 16'd0);
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_hit1", hit1, 1'b0);
    chk("rst_hit2", hit2, 1'b0);
    chk("rst_fwd1", fwd1, 16'd0);
    chk("rst_fwd2", fwd2, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill, ignored fifth push, drain
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].de, 1'b0, 3'd1, 3'd4);
      chk($sformatf("tbl%0d_count", i), s_cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_RegWr", i), s_wr, tbl[i].exp_wr);
      chk($sformatf("tbl%0d_Rd", i), s_rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_WBus", i), s_wb, tbl[i].exp_wb);
      chk($sformatf("tbl%0d_full", i), s_full, tbl[i].exp_full);
    end

    // Forwarding priority
    cyc(1'b1, 3'd5, 16'h1111, 1'b0, 1'b0, 3'd5, 3'd6);
    chk("fwd_push_not_seen", s_hit1, 1'b0);
    cyc(1'b1, 3'd5, 16'h2222, 1'b0, 1'b0, 3'd5, 3'd6);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd5, 3'd6);
    chk("fwd_hit1", s_hit1, 1'b1);
    chk("fwd_fwd1", s_fwd1, 16'h2222);
    chk("fwd_hit2", s_hit2, 1'b0);
    chk("fwd_fwd2", s_fwd2, 16'h0000);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd5, 3'd6);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd5, 3'd6);
    chk("fwd_after_pop1", s_fwd1, 16'h2222);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd5, 3'd6);
    chk("fwd_after_pop2_hit1", s_hit1, 1'b0);

    // Simultaneous push/pop at count 2 across pointer wrap
    cyc(1'b1, 3'd6, 16'h6060, 1'b0, 1'b0, 3'd6, 3'd0);
    cyc(1'b1, 3'd0, 16'h0F0F, 1'b0, 1'b0, 3'd6, 3'd0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 3'(k % 8), 16'hA000 + 16'(k), 1'b1, 1'b0,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      chk($sformatf("wrap%0d_count", k), s_cnt, 3'd2);
    end
    for (int k = 0; k < 8 && sb.size() != 0; k++) idle(1'b1);

    // Flush with head write in progress
    cyc(1'b1, 3'd1, 16'h0101, 1'b0, 1'b0, 3'd4, 3'd1);
    cyc(1'b1, 3'd2, 16'h0202, 1'b0, 1'b0, 3'd4, 3'd1);
    cyc(1'b1, 3'd3, 16'h0303, 1'b0, 1'b0, 3'd4, 3'd1);
    cyc(1'b1, 3'd4, 16'h4444, 1'b1, 1'b1, 3'd4, 3'd1);
    chk("flush_RegWr", s_wr, 1'b1);
    chk("flush_Rd", s_rd, 3'd1);
    chk("flush_WBus", s_wb, 16'h0101);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd4, 3'd1);
    chk("post_flush_count", s_cnt, 3'd0);
    chk("post_flush_empty", s_empty, 1'b1);
    chk("post_flush_hit1", s_hit1, 1'b0);
    chk("post_flush_hit2", s_hit2, 1'b0);

    // Async reset mid-drain
    cyc(1'b1, 3'd2, 16'h0D02, 1'b0, 1'b0, 3'd2, 3'd3);
    cyc(1'b1, 3'd3, 16'h0D03, 1'b0, 1'b0, 3'd2, 3'd3);
    push_valid = 1'b0;
    drain_en = 1'b1;
    Rs1 = 3'd2;
    #2;
    chk("pre_reset_RegWr", RegWr, 1'b1);
    reset = 1'b1;
    #1;
    chk("areset_RegWr", RegWr, 1'b0);
    chk("areset_count", count, 3'd0);
    chk("areset_empty", empty, 1'b1);
    chk("areset_hit1", hit1, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    drain_en = 1'b0;
    @(posedge clk);
    #1;

    // Push into empty buffer: no flow-through
    cyc(1'b1, 3'd7, 16'hBEEF, 1'b1, 1'b0, 3'd7, 3'd0);
    chk("empty_push_RegWr0", s_wr, 1'b0);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd7, 3'd0);
    chk("empty_push_RegWr1", s_wr, 1'b1);
    chk("empty_push_Rd", s_rd, 3'd7);
    chk("empty_push_WBus", s_wb, 16'hBEEF);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
